ex_hilo_muldiv: RTL and testbench

Execute-stage iterative multiply/divide unit with HI/LO registers; consumes ID/EX outputs (RD1/RD2 operands, decoded mul/div op, HI/LO write controls).
- Executes MULT/MULTU/DIV/DIVU over 32 iterations.
- Services MTHI/MTLO writes.
- Raises busy so the hazard unit can freeze the PC, IF/ID and ID/EX (drives their enable low) until HI/LO are valid.

---
 rtl/ex_hilo_muldiv.sv | 179 +++++++++++++++++
 tb/tb_ex_hilo_muldiv.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/ex_hilo_muldiv.sv
// Execute-stage iterative multiply/divide unit owning the HI/LO registers.
// One radix-2 step per cycle; busy stalls the front end until HI/LO are valid.
module ex_hilo_muldiv #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned ITER  = 32   // must equal WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             hi_we,
   input  logic             lo_we,
   input  logic             flush,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int unsigned CNT_W = (ITER > 1) ? $clog2(ITER) : 1;
   localparam int unsigned DW    = 2 * WIDTH;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_CALC   = 2'd1,
      S_FINISH = 2'd2
   } state_e;

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [1:0]         op_q, op_d;
   logic [DW-1:0]      acc_q, acc_d;      // {hi/remainder, lo/multiplier/quotient}
   logic [WIDTH-1:0]   opb_q, opb_d;      // multiplicand or divisor magnitude
   logic [WIDTH-1:0]   a_raw_q, a_raw_d;
   logic               neg_q, neg_d;
   logic               sa_q, sa_d;
   logic               dz_q, dz_d;
   logic [WIDTH-1:0]   hi_q, hi_d;
   logic [WIDTH-1:0]   lo_q, lo_d;
   logic               done_q, done_d;

   logic               a_sgn, b_sgn;
   logic [WIDTH-1:0]   a_mag, b_mag;
   logic [WIDTH:0]     mul_sum;
   logic [DW-1:0]      mul_next;
   logic [WIDTH:0]     div_shift;
   logic [WIDTH:0]     div_diff;
   logic               div_ge;
   logic [DW-1:0]      div_next;
   logic [DW-1:0]      prod;
   logic [WIDTH-1:0]   quot, rem;

   // Operand sign/magnitude for the issue cycle; op[0]=1 selects unsigned
   always_comb begin
      a_sgn = ~op[0] & a[WIDTH-1];
      b_sgn = ~op[0] & b[WIDTH-1];
      a_mag = a_sgn ? WIDTH'(-a) : a;
      b_mag = b_sgn ? WIDTH'(-b) : b;
   end

   // Shift-add multiply step and restoring divide step on the shared accumulator
   always_comb begin
      mul_sum   = {1'b0, acc_q[DW-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : '0);
      mul_next  = {mul_sum, acc_q[WIDTH-1:1]};
      div_shift = {acc_q[DW-1:WIDTH], acc_q[WIDTH-1]};
      div_diff  = div_shift - {1'b0, opb_q};
      div_ge    = (div_shift >= {1'b0, opb_q});
      div_next  = {(div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0]),
                   acc_q[WIDTH-2:0], div_ge};
   end

   // Sign correction of the finished magnitudes
   always_comb begin
      prod = (~op_q[0] & neg_q) ? DW'(-acc_q) : acc_q;
      quot = (~op_q[0] & neg_q) ? WIDTH'(-acc_q[WIDTH-1:0]) : acc_q[WIDTH-1:0];
      rem  = (~op_q[0] & sa_q)  ? WIDTH'(-acc_q[DW-1:WIDTH]) : acc_q[DW-1:WIDTH];
   end

   // Next-state and datapath update
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      op_d    = op_q;
      acc_d   = acc_q;
      opb_d   = opb_q;
      a_raw_d = a_raw_q;
      neg_d   = neg_q;
      sa_d    = sa_q;
      dz_d    = dz_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      done_d  = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               if (!flush) begin
                  state_d = S_CALC;
                  cnt_d   = '0;
                  op_d    = op;
                  acc_d   = {{WIDTH{1'b0}}, a_mag};
                  opb_d   = b_mag;
                  a_raw_d = a;
                  neg_d   = a_sgn ^ b_sgn;
                  sa_d    = a_sgn;
                  dz_d    = (b == '0);
               end
            end else begin
               if (hi_we) hi_d = a;
               if (lo_we) lo_d = a;
            end
         end
         S_CALC: begin
            if (flush) begin
               state_d = S_IDLE;
            end else begin
               acc_d = op_q[1] ? div_next : mul_next;
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == CNT_W'(ITER - 1)) state_d = S_FINISH;
            end
         end
         S_FINISH: begin
            state_d = S_IDLE;
            if (!flush) begin
               done_d = 1'b1;
               if (!op_q[1]) begin
                  hi_d = prod[DW-1:WIDTH];
                  lo_d = prod[WIDTH-1:0];
               end else if (dz_q) begin
                  hi_d = a_raw_q;
                  lo_d = '1;
               end else begin
                  hi_d = rem;
                  lo_d = quot;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         op_q    <= '0;
         acc_q   <= '0;
         opb_q   <= '0;
         a_raw_q <= '0;
         neg_q   <= 1'b0;
         sa_q    <= 1'b0;
         dz_q    <= 1'b0;
         hi_q    <= '0;
         lo_q    <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
         acc_q   <= acc_d;
         opb_q   <= opb_d;
         a_raw_q <= a_raw_d;
         neg_q   <= neg_d;
         sa_q    <= sa_d;
         dz_q    <= dz_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         done_q  <= done_d;
      end
   end

   assign busy = (state_q != S_IDLE);
   assign done = done_q;
   assign hi   = hi_q;
   assign lo   = lo_q;

endmodule

// File: tb/tb_ex_hilo_muldiv.sv
// Directed bench for ex_hilo_muldiv: hand-computed HI/LO results, latency,
// MTHI/MTLO, flush, start-while-busy and asynchronous reset.
module tb_ex_hilo_muldiv;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [1:0]  op;
   logic [31:0] a, b;
   logic        hi_we, lo_we, flush;
   logic        busy, done;
   logic [31:0] hi, lo;

   int n_cmp = 0;
   int n_err = 0;

   ex_hilo_muldiv #(.WIDTH(32), .ITER(32)) dut (
      .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
      .hi_we(hi_we), .lo_we(lo_we), .flush(flush),
      .busy(busy), .done(done), .hi(hi), .lo(lo)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Issue one op at a negedge and watch 40 cycles of busy/done
   task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] va,
                         input logic [31:0] vb, input logic [31:0] ehi, input logic [31:0] elo);
      int nb = 0;
      int nd = 0;
      @(negedge clk);
      start = 1'b1; op = o; a = va; b = vb;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (busy) nb++;
         if (done) begin
            nd++;
            check({tag, " hi@done"}, 64'(hi), 64'(ehi));
            check({tag, " lo@done"}, 64'(lo), 64'(elo));
         end
         @(negedge clk);
      end
      check({tag, " busy_cycles"}, 64'(nb), 64'd33);
      check({tag, " done_pulses"}, 64'(nd), 64'd1);
      check({tag, " hi"}, 64'(hi), 64'(ehi));
      check({tag, " lo"}, 64'(lo), 64'(elo));
   endtask

   initial begin
      int nb, nd;
      rst = 1'b0; start = 1'b0; op = 2'b00; a = '0; b = '0;
      hi_we = 1'b0; lo_we = 1'b0; flush = 1'b0;
      #12;
      check("rst busy", 64'(busy), 64'd0);
      check("rst done", 64'(done), 64'd0);
      check("rst hi", 64'(hi), 64'd0);
      check("rst lo", 64'(lo), 64'd0);
      @(negedge clk);
      rst = 1'b1;

      run_op("MULT -2*3",   2'b00, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
      run_op("MULTU",       2'b01, 32'hFFFF_FFFE, 32'd3, 32'h0000_0002, 32'hFFFF_FFFA);
      run_op("DIV -7/2",    2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
      run_op("DIV 7/-2",    2'b10, 32'd7, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD);
      run_op("DIVU 7/0",    2'b11, 32'd7, 32'd0, 32'h0000_0007, 32'hFFFF_FFFF);
      run_op("DIV min/-1",  2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000);

      // MTHI then MTLO in idle
      @(negedge clk);
      hi_we = 1'b1; a = 32'h1234_5678;
      @(negedge clk);
      hi_we = 1'b0;
      check("MTHI hi", 64'(hi), 64'h1234_5678);
      lo_we = 1'b1; a = 32'h9ABC_DEF0;
      @(negedge clk);
      lo_we = 1'b0;
      check("MTLO lo", 64'(lo), 64'h9ABC_DEF0);
      check("MTLO hi kept", 64'(hi), 64'h1234_5678);

      // start beats hi_we; hi_we while busy ignored; start while busy ignored
      @(negedge clk);
      start = 1'b1; hi_we = 1'b1; op = 2'b01; a = 32'd5; b = 32'd6;
      @(negedge clk);
      start = 1'b0; hi_we = 1'b0;
      check("start wins hi", 64'(hi), 64'h1234_5678);
      nb = 1; nd = 0;
      for (int i = 1; i < 40; i++) begin
         if (i == 4) begin hi_we = 1'b1; a = 32'hDEAD_BEEF; end
         if (i == 5) hi_we = 1'b0;
         if (i == 10) begin start = 1'b1; op = 2'b11; a = 32'd100; b = 32'd7; end
         if (i == 11) start = 1'b0;
         @(negedge clk);
         if (busy) nb++;
         if (done) nd++;
      end
      check("busy ops busy_cycles", 64'(nb), 64'd33);
      check("busy ops done_pulses", 64'(nd), 64'd1);
      check("busy ops hi", 64'(hi), 64'd0);
      check("busy ops lo", 64'(lo), 64'd30);

      // Preload then flush mid-divide
      @(negedge clk);
      hi_we = 1'b1; lo_we = 1'b1; a = 32'hAA;
      @(negedge clk);
      lo_we = 1'b0; a = 32'hBB; lo_we = 1'b1; hi_we = 1'b0;
      @(negedge clk);
      lo_we = 1'b0;
      check("preload hi", 64'(hi), 64'hAA);
      check("preload lo", 64'(lo), 64'hBB);
      start = 1'b1; op = 2'b11; a = 32'd100; b = 32'd7;
      @(negedge clk);
      start = 1'b0;
      nd = 0;
      for (int i = 1; i < 10; i++) begin
         if (done) nd++;
         @(negedge clk);
      end
      check("flush busy before", 64'(busy), 64'd1);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      check("flush busy after", 64'(busy), 64'd0);
      for (int i = 0; i < 35; i++) begin
         if (done) nd++;
         @(negedge clk);
      end
      check("flush done_pulses", 64'(nd), 64'd0);
      check("flush hi", 64'(hi), 64'hAA);
      check("flush lo", 64'(lo), 64'hBB);

      // flush with start in idle suppresses the op
      start = 1'b1; flush = 1'b1; op = 2'b01; a = 32'd3; b = 32'd3;
      @(negedge clk);
      start = 1'b0; flush = 1'b0;
      check("idle flush busy", 64'(busy), 64'd0);

      // Asynchronous reset mid-multiply
      start = 1'b1; op = 2'b01; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF;
      @(negedge clk);
      start = 1'b0;
      repeat (14) @(negedge clk);
      #2 rst = 1'b0;
      #1;
      check("async rst busy", 64'(busy), 64'd0);
      check("async rst hi", 64'(hi), 64'd0);
      check("async rst lo", 64'(lo), 64'd0);
      check("async rst done", 64'(done), 64'd0);
      @(negedge clk);
      rst = 1'b1;
      run_op("DIVU 100/7", 2'b11, 32'd100, 32'd7, 32'd2, 32'd14);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
